// File: rtl/tm1638_driver_types.sv
// Driver-level definitions: behaviour modes, output FSM states, hex font and key-bit mapping.
package tm1638_driver_types;

   localparam int MODE_TOGGLE    = 0;
   localparam int MODE_MOMENTARY = 1;
   localparam int MODE_COUNTER   = 2;

   typedef enum logic [1:0] {OUT_IDLE, OUT_EMIT, OUT_GAP} outState_e;

   // Segment bit 0..6 drives a..g; dp is added by the caller.
   function automatic logic [6:0] hexFont(input logic [3:0] value);
      case (value)
         4'h0: hexFont = 7'h3F;
         4'h1: hexFont = 7'h06;
         4'h2: hexFont = 7'h5B;
         4'h3: hexFont = 7'h4F;
         4'h4: hexFont = 7'h66;
         4'h5: hexFont = 7'h6D;
         4'h6: hexFont = 7'h7D;
         4'h7: hexFont = 7'h07;
         4'h8: hexFont = 7'h7F;
         4'h9: hexFont = 7'h6F;
         4'hA: hexFont = 7'h77;
         4'hB: hexFont = 7'h7C;
         4'hC: hexFont = 7'h39;
         4'hD: hexFont = 7'h5E;
         4'hE: hexFont = 7'h79;
         default: hexFont = 7'h71;
      endcase
   endfunction

   // The TM1638 scatters key k across the four read bytes, two keys per byte.
   function automatic int keyBitIndex(input int key);
      return 8 * (key % 4) + 4 * (key / 4);
   endfunction

endpackage

// File: rtl/tm1638_types.sv
// Shared TM1638 frame types: eight grids of eight segments plus one LED per grid.
package tm1638_types;

   localparam int MAX_GRIDS = 8;

   typedef logic [MAX_GRIDS-1:0][7:0] segments_t;
   typedef logic [MAX_GRIDS-1:0]      leds_t;

endpackage

// File: rtl/tm1638_key_debounce.sv
// Decodes raw TM1638 key words, debounces over consecutive valid reads and flags press events.
module tm1638_key_debounce
   import tm1638_driver_types::*;
#(
   parameter int SPI_READ_WIDTH   = 32,
   parameter int NUM_KEYS         = 8,
   parameter int DEBOUNCE_SAMPLES = 2
)
(
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic                      dataValid_i,
   input  logic [SPI_READ_WIDTH-1:0] data_i,
   output logic [NUM_KEYS-1:0]       accepted_o,
   output logic [NUM_KEYS-1:0]       press_o,
   output logic                      change_o
);

   localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_SAMPLES);

   logic [NUM_KEYS-1:0] decoded;
   logic [NUM_KEYS-1:0] prev_q, prev_d;
   logic [NUM_KEYS-1:0] accepted_q, accepted_d;
   logic [NUM_KEYS-1:0] press_q;
   logic [CW-1:0]       count_q, count_d;
   logic                change_q;
   logic                unusedData;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_decode
      assign decoded[k] = data_i[keyBitIndex(k)];
   end

   assign unusedData = ^data_i;

   // The count saturates at the threshold so a held key keeps re-accepting the same vector harmlessly.
   always_comb begin
      prev_d     = prev_q;
      count_d    = count_q;
      accepted_d = accepted_q;
      if (dataValid_i) begin
         prev_d = decoded;
         if (decoded != prev_q) begin
            count_d = CW'(1);
         end else if (count_q != COUNT_MAX) begin
            count_d = count_q + CW'(1);
         end
         if (count_d == COUNT_MAX) begin
            accepted_d = decoded;
         end
      end
   end

   always_ff @(negedge clock_i) begin
      if (reset_i) begin
         prev_q     <= '0;
         count_q    <= '0;
         accepted_q <= '0;
         press_q    <= '0;
         change_q   <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         count_q    <= count_d;
         accepted_q <= accepted_d;
         press_q    <= accepted_d & ~accepted_q;
         change_q   <= (accepted_d != accepted_q);
      end
   end

   assign accepted_o = accepted_q;
   assign press_o    = press_q;
   assign change_o   = change_q;

endmodule

// File: rtl/tm1638_key_display.sv
// Turns debounced TM1638 key activity into LED/segment frames and paces them with a one-cycle valid pulse.
module tm1638_key_display
   import tm1638_types::*;
   import tm1638_driver_types::*;
#(
   parameter int SPI_READ_WIDTH   = 32,
   parameter int NUM_KEYS         = 8,
   parameter int DEBOUNCE_SAMPLES = 2,
   parameter int MODE             = 0,
   parameter int REFRESH_CYCLES   = 0
)
(
   input  logic                      i_Clk,
   input  logic                      i_Rst,
   input  logic                      i_Data_Valid,
   input  logic [SPI_READ_WIDTH-1:0] i_Data,
   output segments_t                 o_Segments,
   output leds_t                     o_Leds,
   output logic                      o_Valid
);

   localparam logic [31:0] REFRESH_RELOAD =
      (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;

   logic [NUM_KEYS-1:0]      accepted, press;
   logic                     change;
   logic [NUM_KEYS-1:0]      toggle_q, toggle_d;
   logic [NUM_KEYS-1:0][3:0] counter_q, counter_d;
   segments_t                frameSeg, segments_q;
   leds_t                    frameLed, leds_q;
   outState_e                state_q;
   logic                     valid_q, pending_q, startup_q;
   logic [31:0]              refresh_q;
   logic                     frameChange, refreshExpire, newRequest, request;
   logic                     unusedSignals;

   tm1638_key_debounce #(
      .SPI_READ_WIDTH  (SPI_READ_WIDTH),
      .NUM_KEYS        (NUM_KEYS),
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
   ) uDebounce (
      .clock_i    (i_Clk),
      .reset_i    (i_Rst),
      .dataValid_i(i_Data_Valid),
      .data_i     (i_Data),
      .accepted_o (accepted),
      .press_o    (press),
      .change_o   (change)
   );

   // The frame is built from next-state values so an emit lands in the same cycle as the key update.
   for (genvar k = 0; k < MAX_GRIDS; k++) begin : g_grid
      if (k < NUM_KEYS) begin : g_used
         assign toggle_d[k]  = toggle_q[k] ^ press[k];
         assign counter_d[k] = counter_q[k] + {3'b000, press[k]};
         assign frameLed[k]  = (MODE == MODE_TOGGLE) ? toggle_d[k] : accepted[k];
         assign frameSeg[k]  = (MODE == MODE_COUNTER) ? {accepted[k], hexFont(counter_d[k])}
                                                      : {8{frameLed[k]}};
      end else begin : g_blank
         assign frameLed[k] = 1'b0;
         assign frameSeg[k] = 8'h00;
      end
   end

   // In TOGGLE a release leaves the frame untouched; in the other modes any accepted change is visible.
   assign frameChange   = (MODE == MODE_TOGGLE) ? (|press) : change;
   assign refreshExpire = (REFRESH_CYCLES != 0) && (refresh_q == 32'd0);
   assign newRequest    = frameChange | refreshExpire | startup_q;
   assign request       = newRequest | pending_q;
   assign unusedSignals = ^{accepted, change};

   // Output pacing: requests arriving in EMIT or GAP merge into pending and go out on the next IDLE.
   always_ff @(negedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= OUT_IDLE;
         valid_q    <= 1'b0;
         pending_q  <= 1'b0;
         startup_q  <= 1'b1;
         refresh_q  <= '0;
         segments_q <= '0;
         leds_q     <= '0;
         toggle_q   <= '0;
         counter_q  <= '0;
      end else begin
         toggle_q  <= toggle_d;
         counter_q <= counter_d;
         startup_q <= 1'b0;
         valid_q   <= 1'b0;
         if (refresh_q != 32'd0) begin
            refresh_q <= refresh_q - 32'd1;
         end
         case (state_q)
            OUT_IDLE: begin
               if (request) begin
                  state_q   <= OUT_EMIT;
                  valid_q   <= 1'b1;
                  pending_q <= 1'b0;
                  refresh_q <= REFRESH_RELOAD;
                  if (!startup_q) begin
                     segments_q <= frameSeg;
                     leds_q     <= frameLed;
                  end
               end
            end
            OUT_EMIT: begin
               state_q   <= OUT_GAP;
               pending_q <= pending_q | newRequest;
            end
            default: begin
               state_q   <= OUT_IDLE;
               pending_q <= pending_q | newRequest;
            end
         endcase
      end
   end

   assign o_Segments = segments_q;
   assign o_Leds     = leds_q;
   assign o_Valid    = valid_q;

endmodule

// File: tb/tb_tm1638_key_display.sv
// Directed bench: four instances (toggle, momentary, counter, toggle with refresh) share one key stimulus.
module tb_tm1638_key_display;
   import tm1638_types::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        dataValid;
   logic [31:0] data;

   segments_t segs  [4];
   leds_t     leds  [4];
   logic      valid [4];

   int checkCount = 0;
   int failCount  = 0;
   int pulseCount [4] = '{default: 0};
   int backToBack [4] = '{default: 0};
   logic prevValid [4] = '{default: 1'b0};

   tm1638_key_display #(.MODE(0)) dutToggle (
      .i_Clk(clock), .i_Rst(reset), .i_Data_Valid(dataValid), .i_Data(data),
      .o_Segments(segs[0]), .o_Leds(leds[0]), .o_Valid(valid[0]));

   tm1638_key_display #(.MODE(1)) dutMomentary (
      .i_Clk(clock), .i_Rst(reset), .i_Data_Valid(dataValid), .i_Data(data),
      .o_Segments(segs[1]), .o_Leds(leds[1]), .o_Valid(valid[1]));

   tm1638_key_display #(.MODE(2)) dutCounter (
      .i_Clk(clock), .i_Rst(reset), .i_Data_Valid(dataValid), .i_Data(data),
      .o_Segments(segs[2]), .o_Leds(leds[2]), .o_Valid(valid[2]));

   tm1638_key_display #(.MODE(0), .REFRESH_CYCLES(10)) dutRefresh (
      .i_Clk(clock), .i_Rst(reset), .i_Data_Valid(dataValid), .i_Data(data),
      .o_Segments(segs[3]), .o_Leds(leds[3]), .o_Valid(valid[3]));

   always #5 clock = ~clock;

   // Pulse bookkeeping on the rising edge, half a period clear of the DUT's falling-edge updates.
   always @(posedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (valid[i] === 1'b1) pulseCount[i]++;
         if (valid[i] === 1'b1 && prevValid[i] === 1'b1) backToBack[i]++;
         prevValid[i] = valid[i];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d);
      dataValid = v;
      data      = d;
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 32'h0);
   endtask

   task automatic pressRead(input logic [31:0] d);
      applyStimulus(1'b1, d);
      applyStimulus(1'b1, d);
   endtask

   int          base0, base1;
   logic        found;
   logic [29:0] observedPulses;

   initial begin
      reset     = 1'b1;
      dataValid = 1'b0;
      data      = 32'h0;
      repeat (3) @(posedge clock);
      #1;

      // Power-on pulse of a blank frame one cycle after reset falls
      checkOutput("resetLeds", 64'(leds[0]), 64'h0);
      reset = 1'b0;
      idleCycles(1);
      checkOutput("powerOnValid", 64'(valid[0]), 64'h1);
      checkOutput("powerOnSegs", segs[0], 64'h0);
      checkOutput("powerOnCntSegs", segs[2], 64'h0);
      idleCycles(4);
      checkOutput("powerOnCount", 64'(pulseCount[0]), 64'd1);

      // Key 0 press: toggle on, momentary held, counter to 1 with dp
      base0 = pulseCount[0];
      base1 = pulseCount[1];
      pressRead(32'h0000_0001);
      checkOutput("pressNotEarly", 64'(valid[0]), 64'h0);
      idleCycles(1);
      checkOutput("pressLatency", 64'(valid[0]), 64'h1);
      checkOutput("pressLeds", 64'(leds[0]), 64'h01);
      idleCycles(3);
      checkOutput("pressSegs", segs[0], 64'h0000_0000_0000_00FF);
      checkOutput("pressPulses", 64'(pulseCount[0] - base0), 64'd1);
      checkOutput("momPressLeds", 64'(leds[1]), 64'h01);
      checkOutput("momPressSegs", segs[1], 64'h0000_0000_0000_00FF);
      checkOutput("cntPressSegs", segs[2], 64'h3F3F_3F3F_3F3F_3F86);

      // Release: toggle frame unchanged and silent, momentary clears
      base0 = pulseCount[0];
      base1 = pulseCount[1];
      pressRead(32'h0);
      idleCycles(4);
      checkOutput("releasePulses", 64'(pulseCount[0] - base0), 64'd0);
      checkOutput("releaseLeds", 64'(leds[0]), 64'h01);
      checkOutput("momReleaseLeds", 64'(leds[1]), 64'h00);
      checkOutput("momReleasePulses", 64'(pulseCount[1] - base1), 64'd1);
      checkOutput("cntReleaseSegs", segs[2], 64'h3F3F_3F3F_3F3F_3F06);

      // Second press toggles LED 0 back off
      base0 = pulseCount[0];
      pressRead(32'h0000_0001);
      idleCycles(4);
      checkOutput("repressLeds", 64'(leds[0]), 64'h00);
      checkOutput("repressSegs", segs[0], 64'h0);
      checkOutput("repressPulses", 64'(pulseCount[0] - base0), 64'd1);
      checkOutput("cntRepressSegs", segs[2], 64'h3F3F_3F3F_3F3F_3FDB);
      pressRead(32'h0);
      idleCycles(4);

      // Glitch 01/00/01 never reaches two matching reads
      base0 = pulseCount[0];
      base1 = pulseCount[1];
      applyStimulus(1'b1, 32'h0000_0001);
      applyStimulus(1'b1, 32'h0000_0000);
      applyStimulus(1'b1, 32'h0000_0001);
      idleCycles(4);
      checkOutput("glitchPulses", 64'(pulseCount[0] - base0), 64'd0);
      checkOutput("glitchLeds", 64'(leds[0]), 64'h00);
      checkOutput("glitchMomPulses", 64'(pulseCount[1] - base1), 64'd0);
      pressRead(32'h0);
      idleCycles(2);

      // Keys 0,1,5 together; bit 1 is not a key bit and must be ignored
      pressRead(32'h0000_1103);
      idleCycles(4);
      checkOutput("multiLeds", 64'(leds[0]), 64'h23);
      checkOutput("multiSegs", segs[0], 64'h0000_FF00_0000_FFFF);
      checkOutput("momMultiLeds", 64'(leds[1]), 64'h23);
      pressRead(32'h0);
      idleCycles(4);

      // Second acceptance lands in GAP: held pending, emitted on the following IDLE cycle
      base0 = pulseCount[0];
      applyStimulus(1'b1, 32'h0000_0001);
      applyStimulus(1'b1, 32'h0000_0001);
      applyStimulus(1'b1, 32'h0000_0101);
      checkOutput("gapFirstValid", 64'(valid[0]), 64'h1);
      checkOutput("gapFirstLeds", 64'(leds[0]), 64'h22);
      applyStimulus(1'b1, 32'h0000_0101);
      checkOutput("gapEmitLow", 64'(valid[0]), 64'h0);
      idleCycles(1);
      checkOutput("gapGapLow", 64'(valid[0]), 64'h0);
      idleCycles(1);
      checkOutput("gapPendingValid", 64'(valid[0]), 64'h1);
      checkOutput("gapPendingLeds", 64'(leds[0]), 64'h20);
      idleCycles(3);
      checkOutput("gapPulses", 64'(pulseCount[0] - base0), 64'd2);
      pressRead(32'h0);
      idleCycles(4);

      // Reset right before a pending emit aborts it; only the power-on pulse follows
      pressRead(32'h0000_0010);
      reset = 1'b1;
      idleCycles(2);
      checkOutput("midResetValid", 64'(valid[0]), 64'h0);
      checkOutput("midResetLeds", 64'(leds[0]), 64'h00);
      base0 = pulseCount[0];
      reset = 1'b0;
      idleCycles(4);
      checkOutput("midResetPulses", 64'(pulseCount[0] - base0), 64'd1);
      checkOutput("midResetLedsAfter", 64'(leds[0]), 64'h00);
      checkOutput("cntBlankAfterReset", segs[2], 64'h0);

      // Key 4 (bit 4) pressed 17 times: counter wraps F->0 then shows 1
      for (int i = 1; i <= 17; i++) begin
         pressRead(32'h0000_0010);
         idleCycles(3);
         if (i == 16) checkOutput("cnt16Held", segs[2], 64'h3F3F_3FBF_3F3F_3F3F);
         pressRead(32'h0);
         idleCycles(3);
         if (i == 16) checkOutput("cnt16Released", segs[2], 64'h3F3F_3F3F_3F3F_3F3F);
      end
      checkOutput("cnt17Segs", segs[2], 64'h3F3F_3F06_3F3F_3F3F);

      // Refresh with no key activity: a pulse every 10 cycles and an unchanged frame
      found = 1'b0;
      for (int i = 0; i < 25 && !found; i++) begin
         idleCycles(1);
         if (valid[3] === 1'b1) found = 1'b1;
      end
      checkOutput("refreshFound", 64'(found), 64'h1);
      observedPulses = '0;
      for (int i = 0; i < 30; i++) begin
         idleCycles(1);
         observedPulses[i] = (valid[3] === 1'b1);
      end
      checkOutput("refreshSpacing", 64'(observedPulses), 64'h2008_0200);
      checkOutput("refreshLeds", 64'(leds[3]), 64'h10);
      checkOutput("refreshSegs", segs[3], 64'h0000_00FF_0000_0000);

      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("backToBack%0d", i), 64'(backToBack[i]), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/tm1638_key_display.md
TM1638_KEY_DISPLAY -- requirements
Module: tm1638_key_display

Interface
REQ-001 Parameter SPI_READ_WIDTH, 32, width of the key word read from the TM1638; the block SHALL support only 32.
REQ-002 Parameter NUM_KEYS, 8, keys and grids in use; legal range 1..8.
REQ-003 Parameter DEBOUNCE_SAMPLES, 2, consecutive identical valid reads needed to accept a key vector; must be >=1.
REQ-004 Parameter MODE, 0, behaviour: 0 TOGGLE, 1 MOMENTARY, 2 COUNTER.
REQ-005 Parameter REFRESH_CYCLES, 0, clock cycles between forced re-sends; 0 disables refresh.
REQ-006 i_Clk  input  1  sole clock; all state SHALL update on its falling edge.
REQ-007 i_Rst  input  1  reset, synchronous, active-high.
REQ-008 i_Data_Valid  input  1  i_Data holds a fresh key read this cycle.
REQ-009 i_Data  input  SPI_READ_WIDTH  raw key word from the SPI reader.
REQ-010 o_Segments  output  segments_t  [grid][segment]; segment 0..6 = a..g, 7 = dp.
REQ-011 o_Leds  output  leds_t  one LED per grid.
REQ-012 o_Valid  output  1  single-cycle pulse: o_Segments/o_Leds are a complete frame to send.

Function
REQ-013 Key k (0..NUM_KEYS-1) SHALL be decoded as i_Data[8*(k mod 4) + 4*(k div 4)]; other bits are ignored.
REQ-014 Debounce SHALL count consecutive i_Data_Valid reads whose decoded vector equals the previous read; when the count reaches DEBOUNCE_SAMPLES, the vector becomes the accepted vector.
REQ-015 A differing read SHALL restart the count at 1; cycles without i_Data_Valid SHALL neither advance nor clear it.
REQ-016 A press event for key k SHALL be a 0->1 transition of accepted bit k; several bits may change in one acceptance and all SHALL be processed together.
REQ-017 TOGGLE: each press inverts LED k; digit k = 8'hFF when LED k is set, else 8'h00.
REQ-018 MOMENTARY: LED k = accepted bit k; digit k = 8'hFF while held, else 8'h00.
REQ-019 COUNTER: each press increments a 4-bit per-key counter, wrapping F->0; digit k = hex font of the counter, dp = accepted bit k.
REQ-020 Grids and LEDs >= NUM_KEYS SHALL be 0.
REQ-021 Outputs SHALL be registered; a frame change SHALL be visible on the falling edge after the accepting read, with o_Valid high in that same cycle.
REQ-022 Output FSM SHALL be IDLE -> EMIT (o_Valid=1, one cycle) -> GAP (one cycle) -> IDLE; o_Valid is never high on two consecutive cycles.
REQ-023 An update request (frame change, refresh expiry, or power-on) in EMIT or GAP SHALL be held pending and emitted on the next IDLE cycle; multiple pending requests SHALL merge into one pulse carrying the latest frame.
REQ-024 Refresh counter SHALL reload at every EMIT and request a pulse after REFRESH_CYCLES cycles without one; frame content is unchanged.
REQ-025 An acceptance with no visible frame change (e.g. a release in TOGGLE) SHALL NOT request a pulse.

Reset
REQ-026 While i_Rst is high: o_Segments=0, o_Leds=0, o_Valid=0, accepted vector=0, debounce count=0, counters=0, refresh counter=0, FSM=IDLE, no request pending.
REQ-027 The first cycle after i_Rst falls SHALL emit one power-on pulse of the blank frame.
REQ-028 Reset asserted mid-debounce or mid-EMIT SHALL abort it; no pending request survives.

Structure
REQ-029 The MODE encodings, hex font table (0..F -> 7-segment code) and the key-bit mapping function SHALL live in tm1638_driver_types; segments_t/leds_t come from tm1638_types.
REQ-030 Debounce and edge detection SHALL be one sub-module, tm1638_key_debounce, outputting the accepted vector and press events.

Verification
REQ-031 Reset release, MODE=0 -> one o_Valid pulse 1 cycle later, o_Segments=0, o_Leds=0.
REQ-032 MODE=0, DEBOUNCE_SAMPLES=2, two valid reads of 32'h0000_0001 -> o_Leds=8'h01, grid 0 = 8'hFF, one pulse; release, then press again -> o_Leds=8'h00.
REQ-033 Glitch: reads 32'h01, 32'h00, 32'h01 with DEBOUNCE_SAMPLES=2 -> no frame change, no pulse.
REQ-034 MODE=2: key 4 (i_Data bit 4) pressed and released 17 times -> digit 4 shows font '1'; 16 presses -> '0'.
REQ-035 REFRESH_CYCLES=10, no key activity -> o_Valid pulses exactly every 10 cycles, frame constant.
REQ-036 Frame change accepted in the GAP cycle -> pulse on the next IDLE cycle with the new frame, never back-to-back.
